// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the decode/execute issue controller: FSM encodings and
// register-file geometry.
package issue_ctrl_pkg;

  localparam int NREG      = 16;
  localparam int REG_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode-to-issue handshake bundle. The decoder side is the master and the
// issue controller is the slave.
interface issue_ctrl_if
  import issue_ctrl_pkg::*;
#(
  parameter int NREG  = issue_ctrl_pkg::NREG,
  parameter int CNT_W = 16
);
  logic                 dec_valid;
  logic                 re1;
  logic [REG_IDX_W-1:0] op1_ri;
  logic                 re2;
  logic [REG_IDX_W-1:0] op2_ri;
  logic                 wre;
  logic [REG_IDX_W-1:0] wr_ri;
  logic                 pc_halt;
  logic                 resume;

  logic                 issue;
  logic                 stall;
  logic                 halted;
  logic                 busy;
  logic [NREG-1:0]      pend_mask;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output dec_valid, re1, op1_ri, re2, op2_ri, wre, wr_ri, pc_halt, resume,
    input  issue, stall, halted, busy, pend_mask, stall_cnt
  );

  modport slave (
    input  dec_valid, re1, op1_ri, re2, op2_ri, wre, wr_ri, pc_halt, resume,
    output issue, stall, halted, busy, pend_mask, stall_cnt
  );
endinterface

// File: rtl/issue_ctrl_wb_scoreboard.sv
// Fixed-latency writeback scoreboard: a shift register of pending destination
// registers, one slot per pipeline stage between issue and register-file write.
module wb_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int NREG   = issue_ctrl_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_v,
  input  logic [REG_IDX_W-1:0] load_ri,
  input  logic [REG_IDX_W-1:0] rd1_ri,
  input  logic [REG_IDX_W-1:0] rd2_ri,
  output logic                 match1,
  output logic                 match2,
  output logic                 busy,
  output logic                 busy_next,
  output logic [NREG-1:0]      pend_mask
);

  typedef struct packed {
    logic                 v;
    logic [REG_IDX_W-1:0] ri;
  } slot_t;

  slot_t slot_q [WB_LAT];
  slot_t slot_d [WB_LAT];

  // NOTE: every output gets a default before the loops, so no path leaves a latch.
  always_comb begin
    slot_d[0].v  = load_v;
    slot_d[0].ri = load_ri;
    for (int k = 1; k < WB_LAT; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  // NOTE: the slots are a handful of flops, not a RAM, so all of them take reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WB_LAT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < WB_LAT; k++) begin
        // NOTE: non-blocking so every slot shifts from its pre-edge neighbour.
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // The retiring slot still matches: the register file is not write-through.
  always_comb begin
    match1    = 1'b0;
    match2    = 1'b0;
    busy      = 1'b0;
    busy_next = 1'b0;
    pend_mask = '0;
    for (int k = 0; k < WB_LAT; k++) begin
      if (slot_q[k].v) begin
        busy                    = 1'b1;
        pend_mask[slot_q[k].ri] = 1'b1;
        if (slot_q[k].ri == rd1_ri) match1 = 1'b1;
        if (slot_q[k].ri == rd2_ri) match2 = 1'b1;
      end
      if (slot_d[k].v) busy_next = 1'b1;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Issue/interlock controller: stalls decode on RAW hazards against in-flight
// writes and sequences HALT through drain, halted and resume.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int NREG   = issue_ctrl_pkg::NREG,
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  issue_ctrl_if.slave  bus
);

  logic             match1, match2;
  logic             sb_busy, sb_busy_next;
  logic             hazard, issue, stall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  wb_scoreboard #(.WB_LAT(WB_LAT), .NREG(NREG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .load_v    (issue & bus.wre),
    .load_ri   (bus.wr_ri),
    .rd1_ri    (bus.op1_ri),
    .rd2_ri    (bus.op2_ri),
    .match1    (match1),
    .match2    (match2),
    .busy      (sb_busy),
    .busy_next (sb_busy_next),
    .pend_mask (bus.pend_mask)
  );

  assign hazard = bus.dec_valid & ((bus.re1 & match1) | (bus.re2 & match2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        issue = bus.dec_valid & ~hazard;
        stall = hazard;
        if (hazard && (cnt_q != '1)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (issue && bus.pc_halt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall = 1'b1;
        // Leave once the scoreboard is empty after this cycle's shift.
        if (!sb_busy_next) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        stall = 1'b1;
        if (bus.resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.issue     = issue;
  assign bus.stall     = stall;
  assign bus.halted    = (state_q == ST_HALTED);
  assign bus.busy      = sb_busy;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl at WB_LAT=3 with a 4-bit stall counter.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  issue_ctrl_if #(.NREG(16), .CNT_W(4)) bus ();

  issue_ctrl #(.NREG(16), .WB_LAT(3), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int dv, input int r1, input int o1, input int r2,
                       input int o2, input int w, input int wr, input int h);
    bus.dec_valid = (dv != 0);
    bus.re1       = (r1 != 0);
    bus.op1_ri    = 4'(o1);
    bus.re2       = (r2 != 0);
    bus.op2_ri    = 4'(o2);
    bus.wre       = (w != 0);
    bus.wr_ri     = 4'(wr);
    bus.pc_halt   = (h != 0);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    nop();
    bus.resume = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nop();
    bus.resume = 1'b0;
    tick();
    do_reset();

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_pend", 32'(bus.pend_mask), 0);
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_issue", 32'(bus.issue), 1);
    check("rst_cnt", 32'(bus.stall_cnt), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_issue_idle", 32'(bus.issue), 0);
    tick();

    // resume in RUN has no effect
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    bus.resume = 1'b1;
    #1;
    check("run_resume_issue", 32'(bus.issue), 1);
    check("run_resume_stall", 32'(bus.stall), 0);
    tick();
    bus.resume = 1'b0;
    #1;
    check("run_resume_halted", 32'(bus.halted), 0);
    check("run_resume_issue2", 32'(bus.issue), 1);
    tick();

    // RAW back-to-back: ADDUI r3 then ADDU r4 = r3 + r1
    do_reset();
    drive(1, 1, 1, 0, 0, 1, 3, 0);
    #1;
    check("raw_prod_issue", 32'(bus.issue), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3, 1, 1, 1, 4, 0);
      #1;
      check($sformatf("raw_stall%0d", i), 32'(bus.stall), 1);
      check($sformatf("raw_noissue%0d", i), 32'(bus.issue), 0);
      check($sformatf("raw_pend3_%0d", i), 32'(bus.pend_mask[3]), 1);
      tick();
    end
    #1;
    check("raw_issue", 32'(bus.issue), 1);
    check("raw_unstall", 32'(bus.stall), 0);
    check("raw_cnt", 32'(bus.stall_cnt), 3);
    check("raw_pend_clear", 32'(bus.pend_mask), 0);
    tick();
    nop();
    #1;
    check("raw_cnt_hold", 32'(bus.stall_cnt), 3);
    check("raw_pend_r4", 32'(bus.pend_mask), 32'h0010);
    tick();

    // Independent stream of 10 ALU ops
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 1, 2, 1, 6 + i, 0);
      #1;
      check($sformatf("ind_issue%0d", i), 32'(bus.issue), 1);
      check($sformatf("ind_stall%0d", i), 32'(bus.stall), 0);
      check($sformatf("ind_busy%0d", i), 32'(bus.busy), (i > 0) ? 1 : 0);
      tick();
    end
    nop();
    #1;
    check("ind_cnt", 32'(bus.stall_cnt), 0);
    tick();

    // Gated reads: write r0, LD with re1=0/op1=0, ST reading r0
    do_reset();
    drive(1, 1, 1, 0, 0, 1, 0, 0);
    #1;
    check("gate_prod_issue", 32'(bus.issue), 1);
    tick();
    drive(1, 0, 0, 1, 2, 1, 7, 0);
    #1;
    check("gate_ld_issue", 32'(bus.issue), 1);
    check("gate_ld_stall", 32'(bus.stall), 0);
    check("gate_pend0", 32'(bus.pend_mask[0]), 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 1, 2, 0, 0, 0);
      #1;
      check($sformatf("gate_st_stall%0d", i), 32'(bus.stall), 1);
      check($sformatf("gate_st_noissue%0d", i), 32'(bus.issue), 0);
      tick();
    end
    #1;
    check("gate_st_issue", 32'(bus.issue), 1);
    check("gate_st_unstall", 32'(bus.stall), 0);
    tick();

    // HALT drain / halted / resume
    do_reset();
    drive(1, 1, 1, 1, 2, 1, 5, 0);
    #1;
    check("halt_prod_issue", 32'(bus.issue), 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("halt_issue", 32'(bus.issue), 1);
    check("halt_nostall", 32'(bus.stall), 0);
    tick();
    drive(1, 1, 1, 1, 2, 1, 6, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("drain_stall%0d", i), 32'(bus.stall), 1);
      check($sformatf("drain_noissue%0d", i), 32'(bus.issue), 0);
      check($sformatf("drain_halted%0d", i), 32'(bus.halted), 0);
      check($sformatf("drain_busy%0d", i), 32'(bus.busy), 1);
      check($sformatf("drain_pend5_%0d", i), 32'(bus.pend_mask[5]), 1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("hlt_halted%0d", i), 32'(bus.halted), 1);
      check($sformatf("hlt_busy%0d", i), 32'(bus.busy), 0);
      check($sformatf("hlt_stall%0d", i), 32'(bus.stall), 1);
      check($sformatf("hlt_noissue%0d", i), 32'(bus.issue), 0);
      tick();
    end
    bus.resume = 1'b1;
    #1;
    check("resume_halted", 32'(bus.halted), 1);
    check("resume_stall", 32'(bus.stall), 1);
    check("resume_noissue", 32'(bus.issue), 0);
    tick();
    bus.resume = 1'b0;
    #1;
    check("post_resume_halted", 32'(bus.halted), 0);
    check("post_resume_issue", 32'(bus.issue), 1);
    check("post_resume_stall", 32'(bus.stall), 0);
    check("post_resume_cnt", 32'(bus.stall_cnt), 0);
    tick();

    // Reset in the middle of DRAIN with two pending writes
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 6, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("mrst_halt_issue", 32'(bus.issue), 1);
    tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    check("mrst_drain_stall", 32'(bus.stall), 1);
    check("mrst_drain_pend", 32'(bus.pend_mask), 32'h0060);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_halted", 32'(bus.halted), 0);
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_pend", 32'(bus.pend_mask), 0);
    check("mrst_stall", 32'(bus.stall), 0);
    check("mrst_issue", 32'(bus.issue), 1);
    tick();

    // Counter saturation: self-dependent r3 chain stalls 3 of every 4 cycles
    do_reset();
    drive(1, 1, 3, 0, 0, 1, 3, 0);
    repeat (8) tick();
    check("sat_cnt6", 32'(bus.stall_cnt), 6);
    repeat (12) tick();
    check("sat_cnt15", 32'(bus.stall_cnt), 15);
    repeat (20) tick();
    check("sat_cnt_hold", 32'(bus.stall_cnt), 15);
    nop();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
